// File: rtl/sram_resp.sv
// sram_resp: memory-side responder for the core's instruction and data SRAM ports.
// One shared word array, read-first, one-cycle registered read latency,
// per-byte write enables on the data port; the instruction port is read-only.
// Out-of-window accesses and illegal instruction writes raise a sticky error
// and capture the first offending byte address.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   inst_sram_en/wen/addr/wdata  instruction request (wen must be 0, wdata ignored)
//   inst_sram_rdata           instruction word, registered, one cycle after request
//   data_sram_en/wen/addr/wdata  data request with byte-lane write enables
//   data_sram_rdata           data word, registered, one cycle after request
//   err, err_addr             sticky error flag and first error address
module sram_resp #(
  parameter logic [31:0] BASE     = 32'h1fc0_0000,
  parameter int unsigned AW       = 12,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        err,
  output logic [31:0] err_addr
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned LO    = AW + 2;

  logic [31:0] mem [DEPTH];

  logic          inst_hit_c;
  logic          data_hit_c;
  logic [AW-1:0] inst_idx_c;
  logic [AW-1:0] data_idx_c;
  logic          inst_err_c;
  logic          data_err_c;

  // Window decode: upper address bits must match the base, word index below.
  assign inst_hit_c = (inst_sram_addr[31:LO] == BASE[31:LO]);
  assign data_hit_c = (data_sram_addr[31:LO] == BASE[31:LO]);
  assign inst_idx_c = inst_sram_addr[LO-1:2];
  assign data_idx_c = data_sram_addr[LO-1:2];

  // Error sources; idle ports are never checked.
  assign inst_err_c = inst_sram_en && (!inst_hit_c || (inst_sram_wen != 4'b0000));
  assign data_err_c = data_sram_en && !data_hit_c;

  // Byte-lane writes from the data port only; an edge with rst high drops the write.
  always_ff @(posedge clk) begin
    if (!rst && data_sram_en && data_hit_c) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) begin
          mem[data_idx_c][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read-first ports; rdata holds while the port is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_sram_rdata <= 32'h0;
      data_sram_rdata <= 32'h0;
    end else begin
      if (inst_sram_en) begin
        inst_sram_rdata <= inst_hit_c ? mem[inst_idx_c] : ERR_DATA;
      end
      if (data_sram_en) begin
        data_sram_rdata <= data_hit_c ? mem[data_idx_c] : ERR_DATA;
      end
    end
  end

  // Sticky error capture; the data port wins when both fault together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err      <= 1'b0;
      err_addr <= 32'h0;
    end else if (!err && (inst_err_c || data_err_c)) begin
      err      <= 1'b1;
      err_addr <= data_err_c ? data_sram_addr : inst_sram_addr;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{inst_sram_wdata, inst_sram_addr[1:0], data_sram_addr[1:0]};

endmodule

// File: tb/tb_sram_resp.sv
// Directed self-checking bench for sram_resp.
module tb_sram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        err;
  logic [31:0] err_addr;

  int n_chk = 0;
  int n_bad = 0;

  sram_resp dut (
    .clk             (clk),
    .rst             (rst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .err             (err),
    .err_addr        (err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dreq(input logic en, input logic [3:0] wen, input logic [31:0] a, input logic [31:0] d);
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = a;
    data_sram_wdata = d;
  endtask

  task automatic ireq(input logic en, input logic [3:0] wen, input logic [31:0] a);
    inst_sram_en    = en;
    inst_sram_wen   = wen;
    inst_sram_addr  = a;
    inst_sram_wdata = 32'hDEAD_BEEF;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ireq(1'b0, 4'h0, 32'h0);
    dreq(1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_irdata", inst_sram_rdata, 32'h0);
    chk("rst_drdata", data_sram_rdata, 32'h0);
    chk("rst_err",    32'(err),        32'h0);
    chk("rst_eaddr",  err_addr,        32'h0);

    // Idle ports with garbage address/wen raise no error.
    ireq(1'b0, 4'hF, 32'h8000_0000);
    dreq(1'b0, 4'hF, 32'h8000_0000, 32'h0);
    tick();
    chk("idle_noerr", 32'(err), 32'h0);

    // Byte-lane write then read-back.
    dreq(1'b1, 4'hF, 32'h1fc0_0010, 32'h1122_3344);
    tick();
    dreq(1'b1, 4'h2, 32'h1fc0_0010, 32'h0000_AA00);
    tick();
    chk("lane_readfirst", data_sram_rdata, 32'h1122_3344);
    dreq(1'b1, 4'h0, 32'h1fc0_0010, 32'h0);
    tick();
    chk("lane_read", data_sram_rdata, 32'h1122_AA44);
    chk("lane_noerr", 32'(err), 32'h0);

    // Read-first and same-word collision.
    dreq(1'b1, 4'hF, 32'h1fc0_0010, 32'hCAFE_0000);
    tick();
    dreq(1'b1, 4'hF, 32'h1fc0_0010, 32'h1234_5678);
    ireq(1'b1, 4'h0, 32'h1fc0_0010);
    tick();
    chk("coll_drdata", data_sram_rdata, 32'hCAFE_0000);
    chk("coll_irdata", inst_sram_rdata, 32'hCAFE_0000);
    dreq(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    chk("coll_inext", inst_sram_rdata, 32'h1234_5678);
    chk("coll_dhold", data_sram_rdata, 32'hCAFE_0000);

    // Seed word 0 for later array-unchanged checks.
    ireq(1'b0, 4'h0, 32'h0);
    dreq(1'b1, 4'hF, 32'h1fc0_0000, 32'hA5A5_A5A5);
    tick();

    // Out-of-window write then read.
    dreq(1'b1, 4'hF, 32'h8000_0000, 32'h0000_0000);
    tick();
    chk("oow_err",   32'(err), 32'h1);
    chk("oow_eaddr", err_addr, 32'h8000_0000);
    chk("oow_wrdat", data_sram_rdata, 32'h0);
    dreq(1'b1, 4'h0, 32'h8000_0004, 32'h0);
    tick();
    chk("oow_rdata", data_sram_rdata, 32'h0);
    chk("oow_eaddr_frozen", err_addr, 32'h8000_0000);
    dreq(1'b1, 4'h0, 32'h1fc0_0000, 32'h0);
    tick();
    chk("oow_nochange", data_sram_rdata, 32'hA5A5_A5A5);
    dreq(1'b0, 4'h0, 32'h0, 32'h0);

    // Illegal inst write plus simultaneous data error: data address wins.
    pulse_rst();
    #1;
    chk("rst2_err", 32'(err), 32'h0);
    ireq(1'b1, 4'hF, 32'h1fc0_0000);
    dreq(1'b1, 4'h0, 32'h0000_1000, 32'h0);
    tick();
    chk("both_err",   32'(err), 32'h1);
    chk("both_eaddr", err_addr, 32'h0000_1000);
    chk("both_iread", inst_sram_rdata, 32'hA5A5_A5A5);
    dreq(1'b0, 4'h0, 32'h0, 32'h0);
    ireq(1'b1, 4'h0, 32'h1fc0_0000);
    tick();
    chk("both_nochange", inst_sram_rdata, 32'hA5A5_A5A5);

    // Illegal inst write alone.
    ireq(1'b0, 4'h0, 32'h0);
    pulse_rst();
    ireq(1'b1, 4'h4, 32'h1fc0_0008);
    tick();
    chk("iwen_err",   32'(err), 32'h1);
    chk("iwen_eaddr", err_addr, 32'h1fc0_0008);
    ireq(1'b0, 4'h0, 32'h0);

    // Hold and asynchronous reset.
    dreq(1'b1, 4'hF, 32'h1fc0_0010, 32'h1122_AA44);
    tick();
    dreq(1'b1, 4'h0, 32'h1fc0_0010, 32'h0);
    tick();
    chk("hold_read", data_sram_rdata, 32'h1122_AA44);
    dreq(1'b0, 4'h0, 32'h1fc0_0020, 32'h0);
    repeat (5) tick();
    chk("hold_5cyc", data_sram_rdata, 32'h1122_AA44);
    #1 rst = 1'b1;
    #1;
    chk("async_drdata", data_sram_rdata, 32'h0);
    chk("async_err",    32'(err),        32'h0);
    tick();
    rst = 1'b0;
    dreq(1'b1, 4'h0, 32'h1fc0_0010, 32'h0);
    tick();
    chk("preserved", data_sram_rdata, 32'h1122_AA44);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
